uart_cmd_decoder: RTL

- Receive-side command endpoint for the UART valid/ready character streams; the counterpart of the character-emitting ucmd FSM.
- Consumes ASCII characters from the UART rx FIFO read port and parses hex register commands `Raa<CR>` and `Waa dddd<CR>`.
- Executes each command on a simple register bus.
- Writes the ASCII reply into the UART tx FIFO write port.

---
 rtl/uart_cmd_decoder.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses `Raa<CR>` / `Waa dddd<CR>` hex commands from the
// rx character stream, runs them on a simple register bus and streams the
// ASCII reply (`OK`, hex read data, or `?`, each followed by CR LF) to tx.
module uart_cmd_decoder #(
   parameter int data_width = 8,
   parameter int adr_width  = 8,
   parameter int word_width = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] rdata,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [data_width-1:0] wdata,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [adr_width-1:0]  reg_adr,
   output logic [word_width-1:0] reg_wdata,
   output logic                  reg_we,
   output logic                  reg_re,
   input  logic [word_width-1:0] reg_rdata,
   output logic                  busy
);

   localparam int WORD_DIGITS = word_width / 4;
   localparam int REPLY_MAX   = (WORD_DIGITS + 2 > 4) ? WORD_DIGITS + 2 : 4;
   localparam int IDX_W       = $clog2(REPLY_MAX);

   localparam logic [data_width-1:0] ASC_CR  = data_width'(8'h0D);
   localparam logic [data_width-1:0] ASC_LF  = data_width'(8'h0A);
   localparam logic [data_width-1:0] ASC_SP  = data_width'(8'h20);
   localparam logic [data_width-1:0] ASC_0   = data_width'(8'h30);
   localparam logic [data_width-1:0] ASC_9   = data_width'(8'h39);
   localparam logic [data_width-1:0] ASC_UA  = data_width'(8'h41);
   localparam logic [data_width-1:0] ASC_UF  = data_width'(8'h46);
   localparam logic [data_width-1:0] ASC_LA  = data_width'(8'h61);
   localparam logic [data_width-1:0] ASC_LFH = data_width'(8'h66);
   localparam logic [data_width-1:0] ASC_UR  = data_width'(8'h52);
   localparam logic [data_width-1:0] ASC_LR  = data_width'(8'h72);
   localparam logic [data_width-1:0] ASC_UW  = data_width'(8'h57);
   localparam logic [data_width-1:0] ASC_LW  = data_width'(8'h77);
   localparam logic [data_width-1:0] ASC_UO  = data_width'(8'h4F);
   localparam logic [data_width-1:0] ASC_UK  = data_width'(8'h4B);
   localparam logic [data_width-1:0] ASC_QM  = data_width'(8'h3F);

   typedef enum logic [2:0] {
      IDLE,
      ADR,
      DAT,
      SKIP,
      EXEC,
      RDWAIT,
      SEND
   } state_t;

   typedef enum logic [1:0] {
      RPL_NONE,
      RPL_ERR,
      RPL_OK,
      RPL_READ
   } reply_t;

   state_t                 state;
   state_t                 next_state;
   reply_t                 reply_sel;
   logic                   acc_clear;
   logic                   cmd_write_next;
   logic                   adr_shift;
   logic                   dat_shift;
   logic                   send_advance;
   logic                   take;
   logic                   hex_ok;
   logic [3:0]             hex_nib;
   logic                   is_write;
   logic                   adr_seen;
   logic                   dat_seen;
   logic [adr_width-1:0]   acc_adr;
   logic [word_width-1:0]  acc_dat;
   logic [data_width-1:0]  reply_buf [REPLY_MAX];
   logic [IDX_W-1:0]       reply_idx;
   logic [IDX_W-1:0]       reply_end;

   function automatic logic [data_width-1:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) begin
         return ASC_0 + data_width'(n);
      end
      return ASC_UA + data_width'(n) - data_width'(10);
   endfunction

   assign take   = rvalid & rready;
   assign rready = !rst && (state == IDLE || state == ADR || state == DAT || state == SKIP);
   assign wvalid = (state == SEND);
   assign wdata  = (state == SEND) ? reply_buf[reply_idx] : '0;
   assign busy   = (state == EXEC) || (state == RDWAIT) || (state == SEND);
   assign reg_we = (state == EXEC) && is_write;
   assign reg_re = (state == EXEC) && !is_write;

   // Classify the incoming character as a hex digit and extract its nibble value
   always_comb begin
      hex_ok  = 1'b0;
      hex_nib = 4'h0;
      if (rdata >= ASC_0 && rdata <= ASC_9) begin
         hex_ok  = 1'b1;
         hex_nib = 4'(rdata - ASC_0);
      end else if (rdata >= ASC_UA && rdata <= ASC_UF) begin
         hex_ok  = 1'b1;
         hex_nib = 4'(rdata - ASC_UA + data_width'(10));
      end else if (rdata >= ASC_LA && rdata <= ASC_LFH) begin
         hex_ok  = 1'b1;
         hex_nib = 4'(rdata - ASC_LA + data_width'(10));
      end
   end

   // Command parser and reply sequencer: next state plus one-cycle datapath controls
   always_comb begin
      next_state     = state;
      reply_sel      = RPL_NONE;
      acc_clear      = 1'b0;
      cmd_write_next = 1'b0;
      adr_shift      = 1'b0;
      dat_shift      = 1'b0;
      send_advance   = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               if (rdata == ASC_UR || rdata == ASC_LR) begin
                  next_state = ADR;
                  acc_clear  = 1'b1;
               end else if (rdata == ASC_UW || rdata == ASC_LW) begin
                  next_state     = ADR;
                  acc_clear      = 1'b1;
                  cmd_write_next = 1'b1;
               end else if (rdata != ASC_CR && rdata != ASC_LF) begin
                  next_state = SKIP;
               end
            end
         end
         ADR: begin
            if (take) begin
               if (hex_ok) begin
                  adr_shift = 1'b1;
               end else if (rdata == ASC_SP) begin
                  next_state = (is_write && adr_seen) ? DAT : SKIP;
               end else if (rdata == ASC_CR) begin
                  if (!is_write && adr_seen) begin
                     next_state = EXEC;
                  end else begin
                     next_state = SEND;
                     reply_sel  = RPL_ERR;
                  end
               end else if (rdata != ASC_LF) begin
                  next_state = SKIP;
               end
            end
         end
         DAT: begin
            if (take) begin
               if (hex_ok) begin
                  dat_shift = 1'b1;
               end else if (rdata == ASC_CR) begin
                  if (dat_seen) begin
                     next_state = EXEC;
                  end else begin
                     next_state = SEND;
                     reply_sel  = RPL_ERR;
                  end
               end else if (rdata != ASC_LF) begin
                  next_state = SKIP;
               end
            end
         end
         SKIP: begin
            if (take && rdata == ASC_CR) begin
               next_state = SEND;
               reply_sel  = RPL_ERR;
            end
         end
         EXEC: begin
            if (is_write) begin
               next_state = SEND;
               reply_sel  = RPL_OK;
            end else begin
               next_state = RDWAIT;
            end
         end
         RDWAIT: begin
            next_state = SEND;
            reply_sel  = RPL_READ;
         end
         SEND: begin
            if (wready) begin
               if (reply_idx == reply_end) begin
                  next_state = IDLE;
               end else begin
                  send_advance = 1'b1;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Address/data accumulators and the register bus address/data, latched as EXEC is entered
   always_ff @(posedge clk) begin
      if (rst) begin
         is_write  <= 1'b0;
         adr_seen  <= 1'b0;
         dat_seen  <= 1'b0;
         acc_adr   <= '0;
         acc_dat   <= '0;
         reg_adr   <= '0;
         reg_wdata <= '0;
      end else begin
         if (acc_clear) begin
            is_write <= cmd_write_next;
            adr_seen <= 1'b0;
            dat_seen <= 1'b0;
            acc_adr  <= '0;
            acc_dat  <= '0;
         end
         if (adr_shift) begin
            acc_adr  <= adr_width'({acc_adr, hex_nib});
            adr_seen <= 1'b1;
         end
         if (dat_shift) begin
            acc_dat  <= word_width'({acc_dat, hex_nib});
            dat_seen <= 1'b1;
         end
         if (next_state == EXEC) begin
            reg_adr <= acc_adr;
            if (is_write) begin
               reg_wdata <= acc_dat;
            end
         end
      end
   end

   // Reply buffer: loaded once per command, then walked one character per tx handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         reply_idx <= '0;
         reply_end <= '0;
         for (int i = 0; i < REPLY_MAX; i++) begin
            reply_buf[i] <= '0;
         end
      end else begin
         case (reply_sel)
            RPL_ERR: begin
               reply_buf[0] <= ASC_QM;
               reply_buf[1] <= ASC_CR;
               reply_buf[2] <= ASC_LF;
               reply_end    <= IDX_W'(2);
               reply_idx    <= '0;
            end
            RPL_OK: begin
               reply_buf[0] <= ASC_UO;
               reply_buf[1] <= ASC_UK;
               reply_buf[2] <= ASC_CR;
               reply_buf[3] <= ASC_LF;
               reply_end    <= IDX_W'(3);
               reply_idx    <= '0;
            end
            RPL_READ: begin
               for (int i = 0; i < WORD_DIGITS; i++) begin
                  reply_buf[i] <= hex_char(reg_rdata[(WORD_DIGITS-1-i)*4 +: 4]);
               end
               reply_buf[WORD_DIGITS]   <= ASC_CR;
               reply_buf[WORD_DIGITS+1] <= ASC_LF;
               reply_end                <= IDX_W'(WORD_DIGITS + 1);
               reply_idx                <= '0;
            end
            default: begin
               if (send_advance) begin
                  reply_idx <= reply_idx + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
